// File: rtl/mux_sched_pkg.sv
// Shared types, constants and helpers for the round-robin mux-tree scheduler.
package mux_sched_pkg;

  localparam int NSRC  = 4;
  localparam int SRC_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BYP   = 2'd2
  } state_e;

  function automatic logic [NSRC-1:0] idx2onehot(input logic [SRC_W-1:0] idx);
    return NSRC'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1, mod NSRC.
module rr_pick
  import mux_sched_pkg::*;
(
  input  logic [NSRC-1:0]  req_i,
  input  logic [SRC_W-1:0] ptr_i,
  output logic [SRC_W-1:0] idx_o,
  output logic             vld_o
);

  logic [SRC_W-1:0] cand;

  // Scan farthest-first so the candidate nearest to ptr+1 is the last to overwrite.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = NSRC; k >= 1; k--) begin
      cand = ptr_i + SRC_W'(k);
      if (req_i[cand]) begin
        idx_o = cand;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin select-line scheduler for a 4:1 mux tree with bypass stage.
// Define MUX_SCHED_BYPASS_EN to build in the BYP state and byp_req preemption.
module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic               byp_req,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               lock,
  output logic               sel_in,
  output logic               sel_out,
  output logic               byp_sel,
  output logic [3:0]         gnt,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [SRC_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NSRC-1:0]    gnt_q, gnt_d;
  logic               byp_sel_q, byp_sel_d;
  logic               busy_q, busy_d;

  logic               byp_en;
  logic               rel;
  logic               arb;
  logic [SRC_W-1:0]   pick_ptr;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_vld;

`ifdef MUX_SCHED_BYPASS_EN
  assign byp_en = byp_req;
`else
  logic unused_byp_req;
  assign unused_byp_req = byp_req;
  assign byp_en         = 1'b0;
`endif

  // sel_q doubles as the granted index while in GRANT.
  assign rel      = (state_q == GRANT) && (!req[sel_q] || ((cnt_q == '0) && !lock));
  // A release advances ptr on the same edge, so the picker must already see the new pointer.
  assign pick_ptr = rel ? sel_q : ptr_q;

  rr_pick u_rr_pick (
    .req_i (req),
    .ptr_i (pick_ptr),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    byp_sel_d = byp_sel_q;
    arb       = 1'b0;

    case (state_q)
      IDLE: arb = 1'b1;
      GRANT: begin
        if (rel) begin
          ptr_d = sel_q;
          arb   = 1'b1;
        end else if (byp_en) begin
          // Preemption leaves ptr alone so the preempted source is first in line on exit.
          state_d   = BYP;
          gnt_d     = '0;
          byp_sel_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
`ifdef MUX_SCHED_BYPASS_EN
      BYP: begin
        if (!byp_en) arb = 1'b1;
      end
`endif
      default: begin
        state_d   = IDLE;
        gnt_d     = '0;
        byp_sel_d = 1'b0;
      end
    endcase

    if (arb) begin
      if (byp_en) begin
        state_d   = BYP;
        gnt_d     = '0;
        byp_sel_d = 1'b1;
      end else if (pick_vld) begin
        state_d   = GRANT;
        sel_d     = pick_idx;
        gnt_d     = idx2onehot(pick_idx);
        cnt_d     = dwell;
        byp_sel_d = 1'b0;
      end else begin
        state_d   = IDLE;
        gnt_d     = '0;
        byp_sel_d = 1'b0;
      end
    end

    busy_d = (gnt_d != '0) || byp_sel_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= SRC_W'(NSRC - 1);
      sel_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      byp_sel_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the pre-edge value of the others.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      byp_sel_q <= byp_sel_d;
      busy_q    <= busy_d;
    end
  end

  assign sel_in  = sel_q[0];
  assign sel_out = sel_q[1];
  assign byp_sel = byp_sel_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench for mux_rr_scheduler: directed vectors push expectations, a monitor pops and compares.
module tb_mux_rr_scheduler;

  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [3:0]         req = '0;
  logic               byp_req = 1'b0;
  logic [DWELL_W-1:0] dwell = '0;
  logic               lock = 1'b0;
  logic               sel_in, sel_out, byp_sel, busy;
  logic [3:0]         gnt;

  always #5 clk = ~clk;

  mux_rr_scheduler #(.DWELL_W(DWELL_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .byp_req (byp_req),
    .dwell   (dwell),
    .lock    (lock),
    .sel_in  (sel_in),
    .sel_out (sel_out),
    .byp_sel (byp_sel),
    .gnt     (gnt),
    .busy    (busy)
  );

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       byp;
    logic       busy;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {gnt,sel,byp,busy}=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {gnt, sel_out, sel_in, byp_sel, busy};
  endfunction

  // Inputs for the next edge plus the outputs that edge must produce.
  task automatic step(input logic [3:0] r, input logic b, input logic [3:0] d, input logic l,
                      input logic [3:0] g, input logic [1:0] s, input logic y, input string n);
    exp_t e;
    @(negedge clk);
    req     = r;
    byp_req = b;
    dwell   = d;
    lock    = l;
    e.gnt   = g;
    e.sel   = s;
    e.byp   = y;
    e.busy  = (g != 4'b0000) || y;
    e.name  = n;
    sb_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check(e.name, outs(), {e.gnt, e.sel, e.byp, e.busy});
      end
    end
  end

  initial begin : stim
    #1 rst_n = 1'b0;
    #1 check("reset", outs(), 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single requester, dwell=2: continuous grant to source 0.
    repeat (7) step(4'b0001, 1'b0, 4'd2, 1'b0, 4'b0001, 2'd0, 1'b0, "hold0");
    // Dwell change mid-grant ignored: two more cycles, then source 1.
    repeat (2) step(4'b0011, 1'b0, 4'd0, 1'b0, 4'b0001, 2'd0, 1'b0, "dwell_ignored");
    step(4'b0011, 1'b0, 4'd0, 1'b0, 4'b0010, 2'd1, 1'b0, "reload_period3");
    step(4'b0011, 1'b0, 4'd0, 1'b0, 4'b0001, 2'd0, 1'b0, "rr_wrap");

    // All requesting, dwell=0: one-cycle rotation.
    step(4'b1111, 1'b0, 4'd0, 1'b0, 4'b0010, 2'd1, 1'b0, "rot1");
    step(4'b1111, 1'b0, 4'd0, 1'b0, 4'b0100, 2'd2, 1'b0, "rot2");
    step(4'b1111, 1'b0, 4'd0, 1'b0, 4'b1000, 2'd3, 1'b0, "rot3");
    step(4'b1111, 1'b0, 4'd0, 1'b0, 4'b0001, 2'd0, 1'b0, "rot0");
    step(4'b1111, 1'b0, 4'd0, 1'b0, 4'b0010, 2'd1, 1'b0, "rot1b");

    // Source 2 with dwell=5, request drops after two held cycles.
    step(4'b1111, 1'b0, 4'd5, 1'b0, 4'b0100, 2'd2, 1'b0, "g2_start");
    repeat (2) step(4'b1111, 1'b0, 4'd5, 1'b0, 4'b0100, 2'd2, 1'b0, "g2_hold");
    step(4'b1011, 1'b0, 4'd5, 1'b0, 4'b1000, 2'd3, 1'b0, "g2_drop_to3");
    step(4'b1011, 1'b0, 4'd5, 1'b0, 4'b1000, 2'd3, 1'b0, "g3_hold");
    repeat (2) step(4'b0000, 1'b0, 4'd5, 1'b0, 4'b0000, 2'd3, 1'b0, "idle_sel_hold");

    // Source 2 granted with dwell=1, then bypass request for three cycles.
    step(4'b0100, 1'b0, 4'd1, 1'b0, 4'b0100, 2'd2, 1'b0, "g2_pre_byp");
`ifdef MUX_SCHED_BYPASS_EN
    repeat (3) step(4'b0100, 1'b1, 4'd3, 1'b0, 4'b0000, 2'd2, 1'b1, "byp_active");
    step(4'b0100, 1'b0, 4'd3, 1'b0, 4'b0100, 2'd2, 1'b0, "byp_exit");
    repeat (3) step(4'b0101, 1'b0, 4'd3, 1'b0, 4'b0100, 2'd2, 1'b0, "byp_fresh_dwell");
`else
    repeat (3) step(4'b0100, 1'b1, 4'd3, 1'b0, 4'b0100, 2'd2, 1'b0, "byp_ignored");
    step(4'b0100, 1'b0, 4'd3, 1'b0, 4'b0100, 2'd2, 1'b0, "g2_cont");
    step(4'b0101, 1'b0, 4'd3, 1'b0, 4'b0100, 2'd2, 1'b0, "g2_last");
    repeat (2) step(4'b0101, 1'b0, 4'd3, 1'b0, 4'b0001, 2'd0, 1'b0, "g0_after");
`endif

    // Lock holds source 0 for 10 cycles; dropping it hands over to source 1.
    step(4'b0011, 1'b0, 4'd1, 1'b1, 4'b0001, 2'd0, 1'b0, "lock_start");
    repeat (9) step(4'b0011, 1'b0, 4'd1, 1'b1, 4'b0001, 2'd0, 1'b0, "lock_hold");
    step(4'b0011, 1'b0, 4'd1, 1'b0, 4'b0010, 2'd1, 1'b0, "unlock_to1");
    step(4'b0011, 1'b0, 4'd1, 1'b0, 4'b0010, 2'd1, 1'b0, "g1_hold");

    // Asynchronous reset mid-grant, between clock edges.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req   = '0;
    #1 check("async_reset", outs(), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b0, 4'd0, 1'b0, 4'b0001, 2'd0, 1'b0, "post_rst_src0");
    step(4'b1111, 1'b0, 4'd0, 1'b0, 4'b0010, 2'd1, 1'b0, "post_rst_src1");

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 8'(sb_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_rr_scheduler.md
# mux_rr_scheduler

Round-robin scheduler that owns the select lines of the shared 4:1 mux tree with bypass stage (two inner 2:1 muxes, one outer 2:1 mux, one bypass 2:1 mux). Four requesters contend for the mux output. Each winner gets a bounded dwell window, and an optional bypass requester can preempt. The block sits beside the mux tree and drives only its select inputs; data never passes through it.

## Interface
- `DWELL_W`, default 4: width of the dwell-length input and the internal dwell counter.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  4  level requests; bit i = source i of the mux tree.
- `byp_req`  in  1  bypass-source request (used only with bypass compiled in).
- `dwell`  in  DWELL_W  grant length minus one; sampled at each grant start.
- `lock`  in  1  while high, dwell expiry is ignored for the current grant.
- `sel_in`  out  1  select for both inner muxes (source index bit 0).
- `sel_out`  out  1  select for the outer mux (source index bit 1).
- `byp_sel`  out  1  select for the bypass mux (1 = bypass source).
- `gnt`  out  4  one-hot grant to the requester currently routed; 0 when none.
- `busy`  out  1  high whenever `gnt != 0` or `byp_sel = 1`.

## Operation
- States: IDLE, GRANT, BYP.
- Source index i maps to `{sel_out, sel_in} = i`: 0 = inner-mux-0 a, 1 = inner-mux-0 b, 2 = inner-mux-1 a, 3 = inner-mux-1 b.
- Arbitration point: any cycle in IDLE, or a GRANT release, or a BYP exit.
  - At an arbitration point, `byp_req` wins first.
  - Otherwise the winner is the first set `req` bit scanning from `ptr+1` upward, mod 4.
- On a grant start, the counter loads `dwell`. `gnt`, `sel_in` and `sel_out` take the winner's value.
- In GRANT, the counter decrements each cycle while it is nonzero.
- GRANT releases when the granted `req` bit drops, or when counter==0 and `lock`==0.
  - On release, `ptr` takes the granted index.
  - The same edge re-arbitrates: there are zero bubble cycles, and the next state is BYP, GRANT or IDLE.
- A single persistent requester is re-granted back-to-back with a fresh dwell.
- Bypass preemption: `byp_req` high in GRANT forces BYP at the next edge.
  - `ptr` is not updated, so the preempted source wins again on exit if it is still requesting.
- BYP: `byp_sel`=1, `gnt`=0, `sel_in` and `sel_out` hold. BYP is exited at the first edge with `byp_req` low.
- IDLE: `gnt`=0, `byp_sel`=0, `sel_in` and `sel_out` hold their last value.
- Grant length with request held and `lock` low is `dwell`+1 cycles. `dwell`=0 gives 1 cycle.
- `req` bits for non-granted sources may change freely; they are only examined at arbitration points.

## Timing
- All outputs are registered. A request asserted before edge N shows its grant after edge N (1-cycle latency).
- Release and the next grant share one edge, so a new `gnt` value appears the cycle after the last granted cycle.
- Reset values: state IDLE, `ptr`=3 (source 0 has first priority), counter 0, `sel_in`=0, `sel_out`=0, `byp_sel`=0, `gnt`=0, `busy`=0.
- Reset asserted mid-grant clears all state immediately, with no clock needed.
- `dwell` changes during a grant have no effect until the next grant start.
- `lock` high with `req` held keeps the grant indefinitely. Dropping `lock` with counter already 0 releases at the next edge.

## Configuration
- `MUX_SCHED_BYPASS_EN` defined:
  - BYP state is present.
  - `byp_req` is honoured with preemption as above.
- `MUX_SCHED_BYPASS_EN` undefined:
  - BYP state is absent and `byp_req` is ignored.
  - `byp_sel` is constant 0.
  - Ports are unchanged.

## Structure
- Package `mux_sched_pkg`:
  - state enum (IDLE/GRANT/BYP).
  - constants NSRC=4 and SRC_W=2.
  - index-to-onehot function.
- Sub-module `rr_pick`: combinational round-robin picker taking `req` and `ptr`, producing winner index and a valid flag. It is instantiated once.

## Test plan
- Reset, `req`=0001, `dwell`=2, held: `gnt`=0001 continuously, one counter reload every 3 cycles, `sel_out`/`sel_in`=0/0.
- `req`=1111, `dwell`=0: `gnt` cycles 0001→0010→0100→1000→0001 on consecutive cycles; `{sel_out,sel_in}` cycles 0,1,2,3.
- Source 2 granted with `dwell`=5; `req[2]` drops after 2 cycles: release that edge; next grant goes to source 3 if it is requesting.
- Bypass enabled: source 2 in GRANT, `byp_req` pulsed 3 cycles → `byp_sel`=1 and `gnt`=0 for 3 cycles, then `gnt`=0100 with fresh dwell. Bypass disabled: `gnt` is unaffected.
- `lock`=1 with `req`=0011, `dwell`=1 on source 0: grant held 10 cycles; `lock` low → `gnt`=0010 next cycle.
- `rst_n` low mid-grant, with no clock edge: all outputs 0 immediately; after release, source 0 has priority.
